// File: rtl/instr_loader_pkg.sv
// Shared sizing for the instruction loader and the cpu instruction bus.
package instr_loader_pkg;

    localparam int LOADER_IW    = 9;
    localparam int LOADER_DEPTH = 4;
    localparam int LOADER_AW    = 2;

endpackage

// File: rtl/instr_loader_sync_fifo.sv
// Small synchronous FIFO buffering completed instructions ahead of the issue register.
module sync_fifo
    import instr_loader_pkg::*;
#(
    parameter int W = LOADER_IW,
    parameter int D = LOADER_DEPTH,
    parameter int A = LOADER_AW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         push_acc,
    output logic [W-1:0] rd_data,
    output logic [A:0]   count,
    output logic         full,
    output logic         empty
);

    localparam logic [A:0] FULL_CNT = (A+1)'(D);

    logic [W-1:0] mem_q [D];
    logic [W-1:0] mem_d [D];
    logic [A-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [A:0]   count_q, count_d;
    logic         pop_ok;

    // A full FIFO still accepts a word when an entry leaves on the same edge.
    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        pop_ok   = pop && !empty;
        push_acc = push && (!full || pop_ok);
        mem_d    = mem_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        if (push_acc) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        count_d = count_q + (A+1)'(push_acc) - (A+1)'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    assign rd_data = mem_q[rd_q];
    assign count   = count_q;

endmodule

// File: rtl/instr_loader.sv
// Serial-to-parallel instruction front end: deserializer, FIFO and registered issue stage.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int IW    = LOADER_IW,
    parameter int DEPTH = LOADER_DEPTH,
    parameter int AW    = LOADER_AW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          SDI,
    input  logic          SVALID,
    input  logic          SFRAME,
    input  logic          STALL,
    output logic [IW-1:0] INSTRUCTION,
    output logic          WRITE_EN,
    output logic          FULL,
    output logic          EMPTY,
    output logic          OVERFLOW,
    output logic [AW:0]   COUNT
);

    localparam int BW = $clog2(IW);

    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [IW-2:0] shreg_q, shreg_d;
    logic [IW-1:0] push_word, fifo_rd_data;
    logic [IW-1:0] instr_q, instr_d;
    logic          push_req, push_acc, pop;
    logic          wen_q, wen_d, ovf_q, ovf_d;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   fifo_count;

    // The top bit is never stored: the word completes directly from SDI on its last edge.
    always_comb begin
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        push_word = {SDI, shreg_q};
        if (SFRAME) begin
            bitcnt_d = '0;
            if (SVALID) begin
                shreg_d[0] = SDI;
                bitcnt_d   = BW'(1);
            end
        end else if (SVALID) begin
            if (bitcnt_q == BW'(IW-1)) begin
                push_req = 1'b1;
                bitcnt_d = '0;
            end else begin
                for (int i = 0; i < IW-1; i++) begin
                    if (bitcnt_q == BW'(i)) begin
                        shreg_d[i] = SDI;
                    end
                end
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        pop     = !fifo_empty && !STALL;
        wen_d   = pop;
        instr_d = instr_q;
        if (pop) begin
            instr_d = fifo_rd_data;
        end
        ovf_d = ovf_q | (push_req & ~push_acc);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bitcnt_q <= '0;
            shreg_q  <= '0;
            instr_q  <= '0;
            wen_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            instr_q  <= instr_d;
            wen_q    <= wen_d;
            ovf_q    <= ovf_d;
        end
    end

    sync_fifo #(
        .W (IW),
        .D (DEPTH),
        .A (AW)
    ) u_fifo (
        .clk       (CLK),
        .reset     (RESET),
        .push      (push_req),
        .push_data (push_word),
        .pop       (pop),
        .push_acc  (push_acc),
        .rd_data   (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign INSTRUCTION = instr_q;
    assign WRITE_EN    = wen_q;
    assign FULL        = fifo_full;
    assign EMPTY       = fifo_empty;
    assign OVERFLOW    = ovf_q;
    assign COUNT       = fifo_count;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table plus hand-written corner sequences.
module tb_instr_loader;

    logic       CLK = 1'b0;
    logic       RESET, SDI, SVALID, SFRAME, STALL;
    logic [8:0] INSTRUCTION;
    logic       WRITE_EN, FULL, EMPTY, OVERFLOW;
    logic [2:0] COUNT;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] sb[$];
    bit         toggleStall = 1'b0;
    logic       stallAtEdge = 1'b0;

    typedef struct {
        logic [8:0] word;
        logic       frameFirst;
        logic [8:0] expInstr;
    } vec_t;

    vec_t vecs[6];

    instr_loader dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SDI         (SDI),
        .SVALID      (SVALID),
        .SFRAME      (SFRAME),
        .STALL       (STALL),
        .INSTRUCTION (INSTRUCTION),
        .WRITE_EN    (WRITE_EN),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .OVERFLOW    (OVERFLOW),
        .COUNT       (COUNT)
    );

    always #5 CLK = ~CLK;

    // Remember the STALL level each edge saw, so an issue can be checked against it.
    always @(posedge CLK) stallAtEdge <= STALL;

    // Scoreboard consumer: every issued instruction must be the oldest expected one.
    always @(negedge CLK) begin
        logic [8:0] expWord;
        if (!RESET && WRITE_EN) begin
            total++;
            if (stallAtEdge) begin
                bad++;
                $display("[TB] FAIL issue_while_stalled: got WRITE_EN=1 instr=%03h want no issue", INSTRUCTION);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_issue: got %03h want none", INSTRUCTION);
            end else begin
                expWord = sb.pop_front();
                if (INSTRUCTION !== expWord) begin
                    bad++;
                    $display("[TB] FAIL issue_order: got %03h want %03h", INSTRUCTION, expWord);
                end
            end
        end
    end

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    task shiftBit(input logic b, input logic frame);
        @(negedge CLK);
        if (toggleStall) STALL = ~STALL;
        SDI    = b;
        SVALID = 1'b1;
        SFRAME = frame;
    endtask

    task idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (toggleStall) STALL = ~STALL;
            SDI    = 1'b0;
            SVALID = 1'b0;
            SFRAME = 1'b0;
        end
    endtask

    task applyStimulus(input logic [8:0] w, input logic frameFirst);
        for (int i = 0; i < 9; i++) begin
            shiftBit(w[i], (i == 0) && frameFirst);
        end
    endtask

    task waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        idle(2);
        checkOutput({name, "_drained"}, sb.size(), 0);
        checkOutput({name, "_empty"}, EMPTY, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [8:0] w;
        logic [5:0] weBits;

        vecs[0] = '{9'h000, 1'b0, 9'h000};
        vecs[1] = '{9'h1FF, 1'b0, 9'h1FF};
        vecs[2] = '{9'h155, 1'b1, 9'h155};
        vecs[3] = '{9'h0AA, 1'b0, 9'h0AA};
        vecs[4] = '{9'h101, 1'b1, 9'h101};
        vecs[5] = '{9'h0F0, 1'b0, 9'h0F0};

        RESET = 1'b1; SDI = 1'b0; SVALID = 1'b0; SFRAME = 1'b0; STALL = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_instr", INSTRUCTION, 0);
        checkOutput("rst_wen", WRITE_EN, 0);
        checkOutput("rst_full", FULL, 0);
        checkOutput("rst_empty", EMPTY, 1);
        checkOutput("rst_ovf", OVERFLOW, 0);
        checkOutput("rst_count", COUNT, 0);
        RESET = 1'b0;

        // Table vectors streamed back to back with no stall
        for (int v = 0; v < 6; v++) begin
            sb.push_back(vecs[v].expInstr);
            applyStimulus(vecs[v].word, vecs[v].frameFirst);
            checkOutput("table_ovf", OVERFLOW, 0);
        end
        idle(1);
        waitDrain("table", 40);

        // Latency of a single word
        sb.push_back(9'h1A5);
        applyStimulus(9'h1A5, 1'b0);
        idle(1);
        checkOutput("lat_wen_early", WRITE_EN, 0);
        checkOutput("lat_count", COUNT, 1);
        idle(1);
        checkOutput("lat_wen", WRITE_EN, 1);
        checkOutput("lat_instr", INSTRUCTION, 9'h1A5);
        checkOutput("lat_empty", EMPTY, 1);
        idle(1);
        checkOutput("lat_wen_one_cycle", WRITE_EN, 0);

        // Overflow while stalled, then a 4-cycle burst
        STALL = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            w = 9'(k);
            if (k <= 4) sb.push_back(w);
            applyStimulus(w, 1'b0);
        end
        idle(1);
        checkOutput("ovf_full", FULL, 1);
        checkOutput("ovf_count", COUNT, 4);
        checkOutput("ovf_sticky", OVERFLOW, 1);
        STALL = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            weBits[i] = WRITE_EN;
        end
        checkOutput("burst_pattern", weBits, 6'b001111);
        waitDrain("burst", 20);
        checkOutput("ovf_still_set", OVERFLOW, 1);

        // Async reset mid-word with two words buffered
        STALL = 1'b1;
        applyStimulus(9'h0C3, 1'b0);
        applyStimulus(9'h13C, 1'b0);
        for (int i = 0; i < 4; i++) shiftBit(1'b1, 1'b0);
        checkOutput("pre_rst_count", COUNT, 2);
        #2 RESET = 1'b1;
        #1;
        checkOutput("arst_instr", INSTRUCTION, 0);
        checkOutput("arst_wen", WRITE_EN, 0);
        checkOutput("arst_full", FULL, 0);
        checkOutput("arst_empty", EMPTY, 1);
        checkOutput("arst_ovf", OVERFLOW, 0);
        checkOutput("arst_count", COUNT, 0);
        sb.delete();
        @(negedge CLK);
        RESET = 1'b0; SVALID = 1'b0; STALL = 1'b0;
        sb.push_back(9'h0AB);
        applyStimulus(9'h0AB, 1'b0);
        waitDrain("post_rst", 20);

        // SFRAME discards a partial word, alone and together with a valid bit
        for (int i = 0; i < 4; i++) shiftBit(1'b1, 1'b0);
        @(negedge CLK);
        SVALID = 1'b0; SFRAME = 1'b1;
        sb.push_back(9'h0F0);
        applyStimulus(9'h0F0, 1'b0);
        waitDrain("sframe", 20);
        for (int i = 0; i < 3; i++) shiftBit(1'b1, 1'b0);
        sb.push_back(9'h033);
        applyStimulus(9'h033, 1'b1);
        waitDrain("sframe_bit0", 20);

        // Push into a full FIFO on the same edge as a pop
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        STALL = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 9'h011 + 9'(k);
            sb.push_back(w);
            applyStimulus(w, 1'b0);
        end
        idle(1);
        checkOutput("same_edge_full", FULL, 1);
        w = 9'h155;
        sb.push_back(w);
        for (int i = 0; i < 8; i++) shiftBit(w[i], 1'b0);
        @(negedge CLK);
        STALL = 1'b0; SDI = w[8]; SVALID = 1'b1; SFRAME = 1'b0;
        idle(1);
        checkOutput("same_edge_count", COUNT, 4);
        checkOutput("same_edge_ovf", OVERFLOW, 0);
        waitDrain("same_edge", 30);

        // STALL toggled every cycle under continuous input
        STALL = 1'b0;
        toggleStall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = 9'h0C0 + 9'(k * 37);
            sb.push_back(w);
            applyStimulus(w, 1'b0);
        end
        toggleStall = 1'b0;
        STALL = 1'b0;
        waitDrain("toggle", 60);
        checkOutput("toggle_ovf", OVERFLOW, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
